ifetch_buf: RTL and testbench
=============================

// Module: ifetch_buf
// PURPOSE
//   Fetch stage upstream of the decode/execute pipeline. Owns the PC, drives the imem
//   address and captures the combinational imem read into a small prefetch FIFO.
//   Presents one {instr, pc} per cycle to decode with a valid/stall handshake.
//   Redirects on taken branch/jump from execute.
// PARAMETERS
//   XLEN      32            datapath / PC width
//   DEPTH     2             prefetch FIFO entries (power of 2, >=2)
//   RESET_PC  32'h0000_0000 PC loaded on reset
// PORTS
//   clk        in   1     clock, rising edge
//   reset      in   1     asynchronous, active-low; 0 = reset asserted
//   PCF        out  XLEN  fetch address to imem
//   InstrF     in   32    imem read data for PCF (same-cycle, combinational)
//   PCSrcE     in   1     taken branch/jump in execute; redirect request
//   PCTargetE  in   XLEN  redirect target
//   StallD     in   1     decode cannot accept this cycle
//   ValidD     out  1     InstrD/PCD/PCPlus4D hold a real instruction
//   InstrD     out  32    head instruction; 32'h0000_0013 (NOP) when !ValidD
//   PCD        out  XLEN  PC of InstrD; 0 when !ValidD
//   PCPlus4D   out  XLEN  PCD+4 (mod 2^XLEN); 0 when !ValidD
// BEHAVIOUR
//   - Reset (reset==0, async): PCF=RESET_PC, FIFO count=0, ValidD=0, InstrD=NOP, PCD=0.
//   - Deq: fires when ValidD && !StallD; head entry removed at clock edge.
//   - Enq: fires when !PCSrcE && (count<DEPTH || deq); pushes {InstrF,PCF}; PCF<=PCF+4.
//   - Full (count==DEPTH) without deq: no push, PCF holds (imem re-read same address).
//   - Full with simultaneous deq: push and pop same edge, count unchanged.
//   - Redirect (PCSrcE==1): highest priority, overrides StallD/enq. At edge: FIFO
//     flushed (count=0), PCF<=PCTargetE with bits[1:0] forced to 0, no push. Next cycle
//     ValidD=0; target instr visible on InstrD one cycle later.
//   - Latency: instr fetched at PCF in cycle n is on InstrD earliest cycle n+1.
//   - Outputs InstrD/PCD/PCPlus4D driven from the registered head entry only; no
//     combinational path from InstrF or StallD to them.
//   - PC increment wraps modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000).
//   - FIFO order strictly FIFO; pointers wrap modulo DEPTH.
//   - Reset asserted mid-stream: all state cleared immediately, pending entries lost.
// CONFIGURATION
//   IFETCH_PERF_EN defined: adds outputs FetchCnt[31:0] (enq count) and
//     BubbleCnt[31:0] (cycles with !ValidD and no redirect); both clear on reset,
//     increment by 1, wrap at 2^32, freeze? no - always count.
//   IFETCH_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//   Package ifetch_pkg: XLEN, NOP_INSTR=32'h0000_0013, typedef fetch_entry_t
//     {pc[XLEN-1:0], instr[31:0]}.
//   Sub-module fetch_fifo: generic sync FIFO of fetch_entry_t, DEPTH param, push/pop/
//     flush, count, async active-low reset; ifetch_buf holds PC reg, enq/deq control,
//     output masking and optional counters.
// TESTING
//   1. Release reset, StallD=0, imem word i = 0x100+i -> ValidD rises cycle 1;
//      InstrD 0x100,0x101,... one per cycle; PCD 0,4,8; PCPlus4D 4,8,12.
//   2. StallD=1 for 5 cycles from steady state -> FIFO fills to 2, PCF freezes,
//      InstrD constant; release -> no instr lost or duplicated, order preserved.
//   3. PCSrcE=1, PCTargetE=0x0000_0042 while FIFO full and StallD=1 -> next cycle
//      ValidD=0, PCF=0x40; following cycle PCD=0x40.
//   4. RESET_PC=0xFFFF_FFF8, StallD=0 -> PCD sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
//   5. Assert reset mid-stream with count=2 -> same cycle ValidD=0, InstrD=NOP,
//      PCF=RESET_PC; after release fetch resumes from RESET_PC.
//   6. IFETCH_PERF_EN: 10 free-run cycles then 3 redirects -> FetchCnt and BubbleCnt
//      match scoreboard exactly.

Source files
------------

// File: rtl/ifetch_buf_pkg.sv
// ifetch_pkg: shared widths, NOP encoding and the prefetch entry type.
//   XLEN         datapath / PC width
//   NOP_INSTR    addi x0,x0,0, shown on InstrD whenever no valid instruction is held
//   fetch_entry_t one prefetched {pc, instr} pair
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_buf_if.sv
// ifetch_buf_if: fetch <-> imem/execute/decode bundle.
//   master: fetch buffer side (drives PCF and the decode-facing outputs)
//   slave : environment side (imem data, redirect, decode stall)
interface ifetch_buf_if;
  import ifetch_pkg::*;

  logic [XLEN-1:0] PCF;
  logic [31:0]     InstrF;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            StallD;
  logic            ValidD;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;

  modport master (
    output PCF, ValidD, InstrD, PCD, PCPlus4D,
    input  InstrF, PCSrcE, PCTargetE, StallD
  );

  modport slave (
    input  PCF, ValidD, InstrD, PCD, PCPlus4D,
    output InstrF, PCSrcE, PCTargetE, StallD
  );

endinterface

// File: rtl/ifetch_buf_fifo.sv
// fetch_fifo: sync FIFO of fetch_entry_t with push/pop/flush and occupancy count.
// Latency: pushed entry is visible at head the cycle after the push edge.
// Backpressure: none internally; the owner must not push when full without a pop.
// Ports: clk, reset (async active-low), push/pushData, pop, flush, head, count.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  fetch_entry_t                 pushData,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wrPtr] <= pushData;
  end

  assign head = mem[rdPtr];

endmodule

// File: rtl/ifetch_buf.sv
// ifetch_buf: owns the PC, fetches from imem, buffers {instr,pc} for decode; redirect on PCSrcE.
// Latency: instr read at PCF in cycle n appears on InstrD in cycle n+1 at the earliest.
// Backpressure: StallD holds the head; when the FIFO is full PCF holds and imem is re-read.
// Ports: clk, reset (async active-low), bus (ifetch_buf_if.master),
//        FetchCnt/BubbleCnt only when IFETCH_PERF_EN is defined.
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  ifetch_buf_if.master bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]  FetchCnt,
  output logic [31:0]  BubbleCnt
`endif
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] pcTarget;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    pushData;
  logic            validD;
  logic            deq;
  logic            enq;

  assign validD   = (count != '0);
  assign deq      = validD && !bus.StallD;
  // A pop this edge frees a slot, so a full FIFO can still accept.
  assign enq      = !bus.PCSrcE && ((count < CW'(DEPTH)) || deq);
  assign pcTarget = bus.PCTargetE & ~XLEN'(3);
  assign pushData = '{pc: pcF, instr: bus.InstrF};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (enq),
    .pushData (pushData),
    .pop      (deq),
    .flush    (bus.PCSrcE),
    .head     (head),
    .count    (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcF <= RESET_PC;
    end else if (bus.PCSrcE) begin
      pcF <= pcTarget;
    end else if (enq) begin
      pcF <= pcF + XLEN'(4);
    end
  end

  // Decode outputs come only from the registered head, masked when empty.
  assign bus.PCF      = pcF;
  assign bus.ValidD   = validD;
  assign bus.InstrD   = validD ? head.instr : NOP_INSTR;
  assign bus.PCD      = validD ? head.pc : '0;
  assign bus.PCPlus4D = validD ? head.pc + XLEN'(4) : '0;

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      FetchCnt  <= '0;
      BubbleCnt <= '0;
    end else begin
      if (enq)                       FetchCnt  <= FetchCnt + 32'd1;
      if (!validD && !bus.PCSrcE)    BubbleCnt <= BubbleCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_buf.sv
// tb_ifetch_buf: reference model + scoreboard bench for ifetch_buf.
// DUT A (RESET_PC=0) exercises streaming, stall, redirect, mid-stream reset, perf counters;
// DUT B (RESET_PC=0xFFFF_FFF8) exercises PC wrap.
module tb_ifetch_buf;
  import ifetch_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  always #5 clk = ~clk;

  ifetch_buf_if aIf ();
  ifetch_buf_if bIf ();

  function automatic logic [31:0] imemWord(input logic [31:0] pc);
    return 32'h100 + (pc >> 2);
  endfunction

  assign aIf.InstrF = imemWord(aIf.PCF);
  assign bIf.InstrF = imemWord(bIf.PCF);

`ifdef IFETCH_PERF_EN
  logic [31:0] aFetchCnt, aBubbleCnt, bFetchCnt, bBubbleCnt;
`endif

  ifetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dutA (
    .clk   (clk),
    .reset (rstA),
    .bus   (aIf.master)
`ifdef IFETCH_PERF_EN
    , .FetchCnt (aFetchCnt), .BubbleCnt (aBubbleCnt)
`endif
  );

  ifetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dutB (
    .clk   (clk),
    .reset (rstB),
    .bus   (bIf.master)
`ifdef IFETCH_PERF_EN
    , .FetchCnt (bFetchCnt), .BubbleCnt (bBubbleCnt)
`endif
  );

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model for DUT A: occupancy, PC, expected entries, perf counts.
  fetch_entry_t sbA [$];
  fetch_entry_t sbB [$];
  int          mCnt = 0;
  logic [31:0] mPc = 32'h0;
  logic [31:0] mFetch = 0;
  logic [31:0] mBubble = 0;

  always @(negedge clk) begin : monA
    logic         expV;
    logic         mDeq;
    logic         mEnq;
    fetch_entry_t e;
    if (!rstA) begin
      mCnt = 0; mPc = 32'h0; mFetch = 0; mBubble = 0;
      sbA.delete();
    end
    expV = (mCnt != 0);
    chk("validD", {31'b0, aIf.ValidD}, {31'b0, expV});
    chk("pcF", aIf.PCF, mPc);
`ifdef IFETCH_PERF_EN
    chk("fetchCnt", aFetchCnt, mFetch);
    chk("bubbleCnt", aBubbleCnt, mBubble);
`endif
    if (!expV) begin
      chk("instrNop", aIf.InstrD, NOP_INSTR);
      chk("pcdIdle", aIf.PCD, 32'h0);
      chk("pcPlus4Idle", aIf.PCPlus4D, 32'h0);
    end else if (sbA.size() != 0) begin
      e = sbA[0];
      chk("instrD", aIf.InstrD, e.instr);
      chk("pcD", aIf.PCD, e.pc);
      chk("pcPlus4D", aIf.PCPlus4D, e.pc + 32'd4);
    end
    // advance the model to the state after the coming edge
    if (rstA) begin
      if (aIf.PCSrcE) begin
        mCnt = 0;
        sbA.delete();
        mPc = {aIf.PCTargetE[31:2], 2'b00};
      end else begin
        mDeq = expV && !aIf.StallD;
        mEnq = (mCnt < DEPTH) || mDeq;
        if (!expV) mBubble++;
        if (mDeq) begin
          void'(sbA.pop_front());
          mCnt--;
        end
        if (mEnq) begin
          sbA.push_back('{pc: mPc, instr: imemWord(mPc)});
          mCnt++;
          mPc = mPc + 32'd4;
          mFetch++;
        end
      end
    end
  end

  // DUT B never stalls, so every valid cycle consumes one expected entry.
  always @(negedge clk) begin : monB
    fetch_entry_t e;
    if (rstB && bIf.ValidD && sbB.size() != 0) begin
      e = sbB.pop_front();
      chk("wrapPcD", bIf.PCD, e.pc);
      chk("wrapInstrD", bIf.InstrD, e.instr);
      chk("wrapPcPlus4D", bIf.PCPlus4D, e.pc + 32'd4);
    end
  end

  initial begin
    rstA = 1'b0; rstB = 1'b0;
    aIf.StallD = 1'b0; aIf.PCSrcE = 1'b0; aIf.PCTargetE = 32'h0;
    bIf.StallD = 1'b0; bIf.PCSrcE = 1'b0; bIf.PCTargetE = 32'h0;
    tick(2);

    // streaming from reset, both DUTs
    rstA = 1'b1;
    rstB = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] p;
      p = 32'hFFFF_FFF8 + 32'(i * 4);
      sbB.push_back('{pc: p, instr: imemWord(p)});
    end
    @(negedge clk);
    chk("firstCycleIdle", {31'b0, aIf.ValidD}, 32'h0);
    @(negedge clk);
    chk("firstValid", {31'b0, aIf.ValidD}, 32'h1);
    chk("firstInstr", aIf.InstrD, 32'h100);
    tick(6);

    // stall: FIFO fills, PCF freezes, head holds
    aIf.StallD = 1'b1;
    tick(5);
    aIf.StallD = 1'b0;
    tick(4);

    // redirect while full and stalled
    aIf.StallD = 1'b1;
    tick(3);
    aIf.PCSrcE = 1'b1;
    aIf.PCTargetE = 32'h0000_0042;
    tick(1);
    aIf.PCSrcE = 1'b0;
    aIf.StallD = 1'b0;
    @(negedge clk);
    chk("redirValid", {31'b0, aIf.ValidD}, 32'h0);
    chk("redirPcF", aIf.PCF, 32'h40);
    @(negedge clk);
    chk("redirPcD", aIf.PCD, 32'h40);
    chk("redirInstr", aIf.InstrD, 32'h110);
    tick(3);

    // reset mid-stream with a full FIFO
    aIf.StallD = 1'b1;
    tick(3);
    rstA = 1'b0;
    #1;
    chk("rstValid", {31'b0, aIf.ValidD}, 32'h0);
    chk("rstInstr", aIf.InstrD, NOP_INSTR);
    chk("rstPcF", aIf.PCF, 32'h0);
    tick(1);
    rstA = 1'b1;
    aIf.StallD = 1'b0;
    tick(6);

`ifdef IFETCH_PERF_EN
    // 10 free-run cycles then 3 back-to-back redirects
    rstA = 1'b0;
    tick(1);
    rstA = 1'b1;
    tick(10);
    aIf.PCSrcE = 1'b1;
    aIf.PCTargetE = 32'h200; tick(1);
    aIf.PCTargetE = 32'h300; tick(1);
    aIf.PCTargetE = 32'h400; tick(1);
    aIf.PCSrcE = 1'b0;
    tick(2);
    @(negedge clk);
    chk("perfFetch", aFetchCnt, 32'd12);
    chk("perfBubble", aBubbleCnt, 32'd2);
    tick(1);
`endif

    chk("wrapDrained", 32'(sbB.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
